// File: rtl/d_mem_sync.sv
// Synchronous byte-addressed data memory with byte/half/word access, load extension,
// a configurable read pipeline and misalignment/illegal-size fault pulses.
module d_mem_sync #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addrs,
  input  logic [31:0]       wData,
  output logic [31:0]       rData,
  output logic              rvalid,
  output logic              err
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [IdxW-1:0] idx;
  logic [1:0]      lane;
  logic            fault;
  logic            acc_ld;
  logic            acc_st;
  logic            acc_err;
  logic [3:0]      be;
  logic [31:0]     wd;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^addrs;

  assign idx  = addrs[IdxW+1:2];
  assign lane = addrs[1:0];

  always_comb begin
    fault = 1'b0;
    unique case (size)
      2'b00: fault = 1'b0;
      2'b01: fault = addrs[0];
      2'b10: fault = |addrs[1:0];
      2'b11: fault = 1'b1;
    endcase
  end

  assign acc_ld  = req & ~we & ~fault;
  assign acc_st  = req & we & ~fault;
  assign acc_err = req & fault;

  // Store data is replicated across lanes; the byte enables pick the lanes written.
  always_comb begin
    be = 4'b0000;
    wd = wData;
    case (size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{wData[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{wData[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wData;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (acc_st) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
      end
    end
  end

  // Stage 1: raw word plus access attributes, captured only on accepted loads.
  logic [31:0] s1_word;
  logic [1:0]  s1_lane;
  logic [1:0]  s1_size;
  logic        s1_uns;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_word <= 32'd0;
      s1_lane <= 2'd0;
      s1_size <= 2'd0;
      s1_uns  <= 1'b0;
    end else if (acc_ld) begin
      s1_word <= mem[idx];
      s1_lane <= lane;
      s1_size <= size;
      s1_uns  <= unsigned_ld;
    end
  end

  logic [31:0] shifted;
  logic [15:0] sel_half;
  logic [31:0] s1_data;

  always_comb begin
    shifted  = s1_word >> {s1_lane, 3'b000};
    sel_half = s1_lane[1] ? s1_word[31:16] : s1_word[15:0];
    case (s1_size)
      2'b00:   s1_data = s1_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   s1_data = s1_uns ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: s1_data = s1_word;
    endcase
  end

  logic [READ_LATENCY-1:0] v_q, v_d;
  logic [READ_LATENCY-1:0] e_q, e_d;

  always_comb begin
    v_d    = v_q << 1;
    v_d[0] = acc_ld;
    e_d    = e_q << 1;
    e_d[0] = acc_err;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      e_q <= '0;
    end else begin
      v_q <= v_d;
      e_q <= e_d;
    end
  end

  assign rvalid = v_q[READ_LATENCY-1];
  assign err    = e_q[READ_LATENCY-1];

  // Data stages load only behind a valid load, so each one holds the last result.
  if (READ_LATENCY > 1) begin : g_pipe
    logic [31:0] d_q [READ_LATENCY-1];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < int'(READ_LATENCY) - 1; k++) d_q[k] <= 32'd0;
      end else begin
        if (v_q[0]) d_q[0] <= s1_data;
        for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
          if (v_q[k]) d_q[k] <= d_q[k-1];
        end
      end
    end

    assign rData = d_q[READ_LATENCY-2];
  end else begin : g_direct
    assign rData = s1_data;
  end

endmodule

// File: tb/tb_d_mem_sync.sv
// Bench for d_mem_sync: latency-1 and latency-3 instances share stimulus and are
// checked every cycle against a byte-level reference model and response history.
module tb_d_mem_sync;

  localparam int unsigned MDEPTH = 1024;

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addrs;
  logic [31:0] wData;
  logic [31:0] rdata1, rdata3;
  logic        rvalid1, rvalid3;
  logic        err1, err3;

  d_mem_sync #(.DEPTH(MDEPTH), .ADDR_W(32), .READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addrs(addrs), .wData(wData),
    .rData(rdata1), .rvalid(rvalid1), .err(err1)
  );

  d_mem_sync #(.DEPTH(MDEPTH), .ADDR_W(32), .READ_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addrs(addrs), .wData(wData),
    .rData(rdata3), .rvalid(rvalid3), .err(err3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] mdl [MDEPTH];
  bit          hist_v [0:4095];
  bit          hist_e [0:4095];
  logic [31:0] hist_d [0:4095];
  logic [31:0] last1 = 32'd0;
  logic [31:0] last3 = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz,
                                          input logic u);
    int unsigned n = nbytes(sz);
    int unsigned v = mdl[(a / 4) % MDEPTH];
    v = v >> (8 * (a % 4));
    if (n < 4) begin
      v = v % (1 << (8 * n));
      if (!u && v >= (1 << (8 * n - 1))) v = v - (1 << (8 * n));
    end
    return v;
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int unsigned i = (a / 4) % MDEPTH;
    for (int b = 0; b < int'(nbytes(sz)); b++) begin
      int unsigned pos = (a % 4) + b;
      mdl[i] = (mdl[i] & ~(32'hFF << (8 * pos))) | (((d >> (8 * b)) & 32'hFF) << (8 * pos));
    end
  endtask

  // Response of the request accepted at edge cyc-lat+1 is visible now.
  task automatic check_inst(input int lat, input logic rv, input logic er,
                            input logic [31:0] rd, inout logic [31:0] last);
    int  k  = cyc - lat + 1;
    bit  ev = (k >= 1) ? hist_v[k] : 1'b0;
    bit  ee = (k >= 1) ? hist_e[k] : 1'b0;
    if (ev) last = hist_d[k];
    chk($sformatf("rvalid_l%0d", lat), {31'd0, rv}, {31'd0, ev});
    chk($sformatf("err_l%0d", lat), {31'd0, er}, {31'd0, ee});
    chk($sformatf("rdata_l%0d", lat), rd, last);
  endtask

  task automatic step(input logic r, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    bit          f = is_fault(sz, a);
    bit          ev = r && !w && !f;
    bit          ee = r && f;
    logic [31:0] ed = ev ? mdl_load(a, sz, u) : 32'd0;
    req = r; we = w; size = sz; unsigned_ld = u; addrs = a; wData = d;
    if (r && w && !f) mdl_store(a, sz, d);
    @(posedge clock);
    cyc++;
    hist_v[cyc] = ev;
    hist_e[cyc] = ee;
    hist_d[cyc] = ed;
    #1;
    check_inst(1, rvalid1, err1, rdata1, last1);
    check_inst(3, rvalid3, err3, rdata3, last3);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 1'b0;
    #1;
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_err1", {31'd0, err1}, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_rvalid3", {31'd0, rvalid3}, 32'd0);
    chk("rst_err3", {31'd0, err3}, 32'd0);
    chk("rst_rdata3", rdata3, 32'd0);
    for (int i = 0; i <= 4; i++) begin
      if (cyc >= i) begin
        hist_v[cyc-i] = 1'b0;
        hist_e[cyc-i] = 1'b0;
      end
    end
    last1 = 32'd0;
    last3 = 32'd0;
    @(posedge clock);
    cyc++;
    hist_v[cyc] = 1'b0;
    hist_e[cyc] = 1'b0;
    #1;
    check_inst(1, rvalid1, err1, rdata1, last1);
    check_inst(3, rvalid3, err3, rdata3, last3);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; unsigned_ld = 1'b0;
    addrs = 32'd0; wData = 32'd0;
    #2;
    do_reset();

    // Known contents for the low 16 words used by every later load.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 2'd2, 1'b0, i * 4, $urandom);

    step(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("plan_word", rdata1, 32'hDEADBEEF);
    step(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    chk("plan_byte_s", rdata1, 32'hFFFFFFDE);
    step(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    chk("plan_byte_u", rdata1, 32'h000000DE);
    step(1'b1, 1'b0, 2'd1, 1'b0, 32'h10, 32'd0);
    chk("plan_half_s", rdata1, 32'hFFFFBEEF);
    step(1'b1, 1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("plan_st_byte", rdata1, 32'hDEAD55EF);
    step(1'b1, 1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("plan_st_half", rdata1, 32'h123455EF);

    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'd0);
    chk("plan_err_ld", {31'd0, err1}, 32'd1);
    step(1'b1, 1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF);
    step(1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    step(1'b1, 1'b0, 2'd1, 1'b1, 32'h2, 32'd0);

    step(1'b1, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hA5A5A5A5);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    chk("plan_wrap", rdata1, 32'hA5A5A5A5);

    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0);
    repeat (4) idle();

    // Load in flight when reset hits must vanish; memory must survive.
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0);
    idle();
    do_reset();
    repeat (4) idle();
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    chk("plan_rst_keep", rdata1, 32'hA5A5A5A5);
    repeat (3) idle();

    for (int n = 0; n < 1500; n++) begin
      logic        r = ($urandom_range(0, 3) != 0);
      logic        w = $urandom_range(0, 1) != 0;
      logic [1:0]  sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      logic        u = $urandom_range(0, 1) != 0;
      logic [31:0] a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      step(r, w, sz, u, a, $urandom);
    end
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_mem_sync.md
Name: d_mem_sync

Overview:
Synchronous, parametrised data memory for the datapath. It is the successor of the combinational word memory.
- Byte-addressed, little-endian, single port.
- Byte, halfword and word loads and stores, with sign or zero extension on loads.
- Configurable read pipeline latency.
- Misalignment/illegal-size fault reporting.
Sits between the ALU result/rt register path and the writeback mux.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two, 4..65536)
ADDR_W, 32, width of byte address input
READ_LATENCY, 1, cycles from accepted load to rvalid (1..4)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req  in  1  access request, sampled each rising edge
we  in  1  1 = store, 0 = load (valid with req)
size  in  2  00 byte, 01 half, 10 word, 11 illegal
unsigned_ld  in  1  1 = zero-extend byte/half loads, 0 = sign-extend
addrs  in  ADDR_W  byte address
wData  in  32  store data; byte/half taken from low bits
rData  out  32  load result, extended to 32 bits
rvalid  out  1  one-cycle pulse: rData valid
err  out  1  one-cycle pulse: faulting request

Behaviour:
- Reset: asynchronous, active-high.
  - Clears all pipeline stages. rData=0, rvalid=0, err=0.
  - Memory contents are NOT cleared.
  - A request in flight at reset is discarded. No rvalid/err is produced for it later.
- Address mapping:
  - word index = addrs[log2(DEPTH)+1:2]; byte lane = addrs[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Fault conditions:
  - size=11.
  - size=01 with addrs[0]=1.
  - size=10 with addrs[1:0]!=00.
  - A faulting store writes nothing. A faulting load produces no rvalid.
- Store (req=1, we=1, no fault):
  - Memory is updated at the same rising edge. No response pulse.
  - Byte: lane addrs[1:0] <= wData[7:0].
  - Half: lanes {addrs[1]*2+1, addrs[1]*2} <= wData[15:0].
  - Word: all lanes <= wData.
  - Untouched lanes keep their value.
- Load (req=1, we=0, no fault):
  - Memory word is read at the accepting edge.
  - Lane selection and extension happen in stage 1.
  - Result advances through READ_LATENCY-1 further registers.
  - rvalid=1 and rData=result for exactly one cycle, READ_LATENCY cycles after the accepting edge.
- Fault timing: err is pulsed with the same latency as rvalid, for loads and stores alike. rData is held at its previous value on err.
- Throughput: one request per cycle, fully pipelined, no back-pressure, no busy state.
- Ordering:
  - Responses emerge in request order.
  - A load accepted the cycle after a store to the same word returns the stored data (write-first ordering across cycles).
- rData between pulses: holds the last valid load result (0 after reset).
- req=0: pipeline shifts a bubble; no memory change.

Test Plan:
- Reset then store word 0xDEADBEEF at 0x10; load word 0x10 -> with READ_LATENCY=1, one cycle later rvalid=1, rData=0xDEADBEEF.
- After the above: load byte 0x13 signed -> rData=0xFFFFFFDE; load byte 0x13 unsigned -> 0x000000DE; load half 0x10 signed -> 0xFFFFBEEF.
- Store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF; store half 0x1234 at 0x12, then load word 0x10 -> 0x123455EF.
- Load word at 0x6, store half at 0x3, size=11 at 0x0 -> err pulses 1 cycle each, rvalid stays 0, word 0x0 unchanged.
- DEPTH=1024: store 0xA5A5A5A5 at 0x1000, load 0x0 -> 0xA5A5A5A5 (wrap). READ_LATENCY=3: back-to-back loads 0x0, 0x4, 0x8 -> three rvalid pulses on consecutive cycles, 3 cycles after each request, in order.
- Assert reset one cycle after issuing a load with READ_LATENCY=3 -> rvalid never pulses for that load, rData=0, and memory still holds previously stored values afterwards.
